// File: rtl/imm_pkg.sv
// Shared types for the immediate-decode stage: format enum, opcodes and the
// buffer-entry layout used by both the output and skid registers.
package imm_pkg;

  // Entries are stored at the widest legal datapath; narrower builds use the low bits.
  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [3:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z,
    IMM_CI, IMM_CSS, IMM_CIW, IMM_CL, IMM_CS, IMM_CB, IMM_CJ
  } imm_type_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    imm_type_e           typ;
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] target;
    logic                illegal;
  } imm_entry_t;

endpackage

// File: rtl/imm_decode_pipe_if.sv
// Fetch-side and register-read-side handshake bundle of the immediate-decode stage.
interface imm_decode_pipe_if import imm_pkg::*; #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  imm_type_e       out_type;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_pc, out_target, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_pc, out_target, out_illegal
  );
endinterface

// File: rtl/imm_format.sv
// Combinational opcode -> {format, immediate, illegal} map at XLEN width.
// Compressed (RVC) decode is present only when IMMDEC_RVC_EN is defined.
module imm_format import imm_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output imm_type_e       typ_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  localparam bit RV64 = (XLEN == 64);

  logic [31:0] imm32;
  logic        unused_f3;

  // Every format is first assembled as a 32-bit value whose bit 31 already holds the
  // correct extension bit, so one signed widening covers both sign and zero extension.
  always_comb begin
    typ_o     = IMM_NONE;
    imm32     = '0;
    illegal_o = 1'b0;
    if (inst_i[1:0] == 2'b11) begin
      case (inst_i[6:0])
        OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
          typ_o = IMM_I; imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        end
        OPC_OP_IMM_32: begin
          if (RV64) begin
            typ_o = IMM_I; imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
          end else begin
            illegal_o = 1'b1;
          end
        end
        OPC_STORE: begin
          typ_o = IMM_S; imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        end
        OPC_BRANCH: begin
          typ_o = IMM_B;
          imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          typ_o = IMM_U; imm32 = {inst_i[31:12], 12'b0};
        end
        OPC_JAL: begin
          typ_o = IMM_J;
          imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        end
        OPC_SYSTEM: begin
          if (inst_i[14]) begin
            typ_o = IMM_Z; imm32 = {27'b0, inst_i[19:15]};
          end else begin
            typ_o = IMM_I; imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
          end
        end
        default: illegal_o = 1'b1;
      endcase
    end else begin
`ifdef IMMDEC_RVC_EN
      // Register-only compressed forms (CR/CA) are legal but carry no immediate.
      case ({inst_i[1:0], inst_i[15:13]})
        5'b00_000: begin
          typ_o = IMM_CIW;
          imm32 = {22'b0, inst_i[10:7], inst_i[12:11], inst_i[5], inst_i[6], 2'b00};
        end
        5'b00_010, 5'b00_110: begin
          typ_o = inst_i[15] ? IMM_CS : IMM_CL;
          imm32 = {25'b0, inst_i[5], inst_i[12:10], inst_i[6], 2'b00};
        end
        5'b00_001, 5'b00_101, 5'b00_011, 5'b00_111: begin
          typ_o = inst_i[15] ? IMM_CS : IMM_CL;
          if (!inst_i[14] || RV64) imm32 = {24'b0, inst_i[6:5], inst_i[12:10], 3'b000};
          else                     imm32 = {25'b0, inst_i[5], inst_i[12:10], inst_i[6], 2'b00};
        end
        5'b01_000, 5'b01_010: begin
          typ_o = IMM_CI; imm32 = {{26{inst_i[12]}}, inst_i[12], inst_i[6:2]};
        end
        5'b01_001: begin
          if (RV64) begin
            typ_o = IMM_CI; imm32 = {{26{inst_i[12]}}, inst_i[12], inst_i[6:2]};
          end else begin
            typ_o = IMM_CJ;
            imm32 = {{20{inst_i[12]}}, inst_i[12], inst_i[8], inst_i[10:9], inst_i[6],
                     inst_i[7], inst_i[2], inst_i[11], inst_i[5:3], 1'b0};
          end
        end
        5'b01_011: begin
          typ_o = IMM_CI;
          if (inst_i[11:7] == 5'd2)
            imm32 = {{22{inst_i[12]}}, inst_i[12], inst_i[4:3], inst_i[5], inst_i[2], inst_i[6], 4'b0};
          else
            imm32 = {{14{inst_i[12]}}, inst_i[12], inst_i[6:2], 12'b0};
        end
        5'b01_100: begin
          if (inst_i[11:10] == 2'b10) begin
            typ_o = IMM_CB; imm32 = {{26{inst_i[12]}}, inst_i[12], inst_i[6:2]};
          end else if (inst_i[11:10] != 2'b11) begin
            typ_o = IMM_CB; imm32 = {26'b0, inst_i[12], inst_i[6:2]};
          end
        end
        5'b01_101: begin
          typ_o = IMM_CJ;
          imm32 = {{20{inst_i[12]}}, inst_i[12], inst_i[8], inst_i[10:9], inst_i[6],
                   inst_i[7], inst_i[2], inst_i[11], inst_i[5:3], 1'b0};
        end
        5'b01_110, 5'b01_111: begin
          typ_o = IMM_CB;
          imm32 = {{23{inst_i[12]}}, inst_i[12], inst_i[6:5], inst_i[2], inst_i[11:10], inst_i[4:3], 1'b0};
        end
        5'b10_000: begin
          typ_o = IMM_CI; imm32 = {26'b0, inst_i[12], inst_i[6:2]};
        end
        5'b10_010: begin
          typ_o = IMM_CI; imm32 = {24'b0, inst_i[3:2], inst_i[12], inst_i[6:4], 2'b00};
        end
        5'b10_001, 5'b10_011: begin
          typ_o = IMM_CI;
          if (!inst_i[14] || RV64) imm32 = {23'b0, inst_i[4:2], inst_i[12], inst_i[6:5], 3'b000};
          else                     imm32 = {24'b0, inst_i[3:2], inst_i[12], inst_i[6:4], 2'b00};
        end
        5'b10_110: begin
          typ_o = IMM_CSS; imm32 = {24'b0, inst_i[8:7], inst_i[12:9], 2'b00};
        end
        5'b10_101, 5'b10_111: begin
          typ_o = IMM_CSS;
          if (!inst_i[14] || RV64) imm32 = {23'b0, inst_i[9:7], inst_i[12:10], 3'b000};
          else                     imm32 = {24'b0, inst_i[8:7], inst_i[12:9], 2'b00};
        end
        5'b10_100: typ_o = IMM_NONE;
        default:   illegal_o = 1'b1;
      endcase
`else
      illegal_o = 1'b1;
`endif
    end
  end

  assign imm_o     = XLEN'($signed(imm32));
  assign unused_f3 = ^inst_i[13:12];

endmodule

// File: rtl/imm_decode_pipe.sv
// Registered immediate-decode stage: format map, pc+imm adder and a 2-entry
// (output + skid) buffer. Optional RVC decode via IMMDEC_RVC_EN.
module imm_decode_pipe import imm_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  imm_decode_pipe_if.slave  bus
);

  imm_type_e       fmt_typ;
  logic [XLEN-1:0] fmt_imm;
  logic [XLEN-1:0] fmt_target;
  logic            fmt_illegal;
  imm_entry_t      new_entry;

  imm_entry_t out_q, out_d, skid_q, skid_d;
  logic       out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic       accept, drain;

  imm_format #(.XLEN(XLEN)) u_format (
    .inst_i    (bus.in_inst),
    .typ_o     (fmt_typ),
    .imm_o     (fmt_imm),
    .illegal_o (fmt_illegal)
  );

  assign fmt_target = bus.in_pc + fmt_imm;

  always_comb begin
    new_entry         = '0;
    new_entry.imm     = XLEN_MAX'(fmt_imm);
    new_entry.typ     = fmt_typ;
    new_entry.pc      = XLEN_MAX'(bus.in_pc);
    new_entry.target  = XLEN_MAX'(fmt_target);
    new_entry.illegal = fmt_illegal;
  end

  assign accept = bus.in_valid && !skid_vld_q;
  assign drain  = out_vld_q && bus.out_ready;

  // The skid can only be occupied while the output register is full, so when the
  // output frees up and the skid holds data, in_ready was low and nothing is accepted.
  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || drain) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        if (accept) out_d = new_entry;
        out_vld_d = accept;
      end
    end else if (accept) begin
      skid_d     = new_entry;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.in_ready    = !skid_vld_q;
  assign bus.out_valid   = out_vld_q;
  assign bus.out_imm     = out_q.imm[XLEN-1:0];
  assign bus.out_type    = out_q.typ;
  assign bus.out_pc      = out_q.pc[XLEN-1:0];
  assign bus.out_target  = out_q.target[XLEN-1:0];
  assign bus.out_illegal = out_q.illegal;

  generate
    if (XLEN < XLEN_MAX) begin : g_narrow
      logic unused_hi;
      assign unused_hi = ^{out_q.imm[XLEN_MAX-1:XLEN], out_q.pc[XLEN_MAX-1:XLEN],
                           out_q.target[XLEN_MAX-1:XLEN]};
    end
  endgenerate

endmodule

// File: doc/imm_decode_pipe.md
# imm_decode_pipe

Registered, parametrised immediate-decode stage for the decode pipeline. It takes a raw instruction plus its PC and derives the immediate format from the opcode itself, so no external format select is needed. It emits the sign- or zero-extended immediate at XLEN width, plus pc+imm. It sits between fetch and register-read, uses a valid/ready handshake, and has a 2-entry skid buffer so full throughput is kept under backpressure.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline kill.
- in_valid  input  1  instruction offered.
- in_ready  output  1  stage can accept; equals "skid entry empty".
- in_inst  input  32  raw instruction; compressed instructions occupy bits [15:0].
- in_pc  input  XLEN  instruction address.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts.
- out_imm  output  XLEN  extended immediate.
- out_type  output  4  imm_type_e of the decoded format.
- out_pc  output  XLEN  passthrough of in_pc.
- out_target  output  XLEN  out_pc + out_imm, modulo 2^XLEN.
- out_illegal  output  1  opcode has no known format.

## Operation
- Format from opcode in_inst[6:0]:
  - LOAD, OP-IMM and JALR → I. OP-IMM-32 → I, but only when XLEN=64; otherwise illegal.
  - STORE → S. BRANCH → B. LUI and AUIPC → U. JAL → J.
  - SYSTEM with funct3[2]=1 → Z, where imm = zero-extended in_inst[19:15].
  - SYSTEM with funct3[2]=0 → I.
  - Anything else → NONE, imm=0, illegal=1.
- Extension rules:
  - I, S, B and J are sign-extended from in_inst[31] to XLEN.
  - U is {inst[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
  - Z is zero-extended.
- The adder for out_target has XLEN width; carry-out is dropped.
- Storage is a main output register plus one skid register, each holding {imm, type, pc, target, illegal}.
  - Accept when in_valid && in_ready.
  - If the output register is empty, or is being drained this cycle, the accepted entry goes to the output register.
  - Otherwise it goes to the skid register.
  - When the output register drains and the skid is full, the skid entry moves to the output register and the skid empties.
- Order is strictly FIFO. No entry is ever dropped or duplicated.
- flush clears both valid bits at the next edge. An input accepted in the flush cycle is discarded. Flush takes priority over accept and over drain.
- rst has the same effect as flush and also clears all payload registers to 0.

## Timing
- Latency is 1 cycle: accepted at edge N, out_valid is visible after edge N.
- Throughput is 1 per cycle while out_ready=1.
- in_ready is registered: it is 1 when the skid is empty. It drops the cycle after the second entry is buffered without a drain.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_type=NONE, out_pc=0, out_target=0, out_illegal=0.
- Outputs are stable while out_valid && !out_ready.
- Simultaneous accept and drain with the skid empty: the new entry replaces the output register and in_ready stays 1.
- Reset or flush mid-backpressure: both entries are gone next cycle and in_ready=1.

## Configuration
- IMMDEC_RVC_EN defined:
  - in_inst[1:0] != 2'b11 is decoded as RVC.
  - Supported formats are CI, CSS, CIW, CL, CS, CB and CJ, with immediates scaled and sign- or zero-extended per the C spec.
  - out_target uses the same pc+imm rule.
- IMMDEC_RVC_EN undefined:
  - Any in_inst[1:0] != 2'b11 gives type NONE, imm=0, illegal=1.
  - No RVC logic is synthesised.

## Structure
- The shared package imm_pkg holds:
  - the imm_type_e enum: NONE, I, S, B, U, J, Z, CI, CSS, CIW, CL, CS, CB, CJ;
  - the opcode localparams;
  - the packed struct for a buffer entry.
- Sub-module imm_format is a pure combinational map from inst to {type, imm, illegal} at XLEN width. The skid, handshake and adder live in the top module.

## Test plan
- XLEN=32, pc=0x1000, inst=0xFE000EE3 (beq -4) → next cycle type B, imm=0xFFFFFFFC, target=0x00000FFC.
- XLEN=64, inst=0x800000B7 (lui 0x80000) → type U, imm=0xFFFFFFFF80000000.
- inst=0x3002D073 (csrrwi, zimm=5) → type Z, imm=0x5, illegal=0.
- out_ready=0 for 3 cycles while in_valid=1 with 3 distinct instructions:
  - two are accepted, then in_ready=0;
  - on release, outputs appear in order with no loss.
- Both entries full, flush=1 for 1 cycle → out_valid=0 and in_ready=1 next cycle; the input offered in the flush cycle never appears.
- inst=0x000010FD (c.addi x1,-1):
  - with IMMDEC_RVC_EN → type CI, imm=0xFFFFFFFF;
  - without it → type NONE, imm=0, illegal=1.
